vigna_axi_arbiter: RTL and testbench
====================================

# vigna_axi_arbiter

Two-master to one-slave AXI4-Lite arbiter placed directly downstream of the Vigna AXI4-Lite core wrapper. It merges the core's instruction-read port and data read/write port onto a single AXI4-Lite master port toward the memory/peripheral interconnect. Reads from the two sources are arbitrated round-robin, with one outstanding read at a time. The write channels pass straight through from the data port.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all AR/AW channels
- DATA_WIDTH, 32, data width of R/W channels; strobe width is DATA_WIDTH/8

Ports (s_i_* = instruction master side, s_d_* = data master side, m_* = slave side):
- clk  in  1  single clock; all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- s_i_arvalid/s_i_arready  in/out  1  instruction AR handshake
- s_i_araddr  in  ADDR_WIDTH  instruction read address
- s_i_arprot  in  3  instruction AR protection
- s_i_rvalid/s_i_rready  out/in  1  instruction R handshake
- s_i_rdata  out  DATA_WIDTH, s_i_rresp  out  2  instruction read data/response
- s_d_arvalid/s_d_arready, s_d_araddr, s_d_arprot, s_d_rvalid/s_d_rready, s_d_rdata, s_d_rresp  same as s_i_* for the data port
- s_d_awvalid/s_d_awready, s_d_awaddr, s_d_awprot  data AW channel
- s_d_wvalid/s_d_wready, s_d_wdata, s_d_wstrb  data W channel
- s_d_bvalid/s_d_bready, s_d_bresp  data B channel
- m_arvalid/m_arready, m_araddr, m_arprot, m_rvalid/m_rready, m_rdata, m_rresp  merged read channels
- m_awvalid/m_awready, m_awaddr, m_awprot, m_wvalid/m_wready, m_wdata, m_wstrb, m_bvalid/m_bready, m_bresp  write channels

## Operation
- Read FSM states:
  - R_IDLE: no read in flight.
  - R_ADDR: m_arvalid asserted, waiting for m_arready.
  - R_DATA: waiting for the R beat.
- Transitions:
  - R_IDLE → R_ADDR when any s_*_arvalid is high.
  - R_ADDR → R_DATA on m_arvalid & m_arready.
  - R_DATA → R_IDLE on m_rvalid & m_rready.
- Grant in R_IDLE is combinational:
  - Only one arvalid high: grant that source.
  - Both high: grant the source not recorded in register last_grant.
- Accept: s_x_arready = (state==R_IDLE) & grant_x. It is high for exactly the accept cycle and is never asserted to the non-granted source.
- On accept:
  - latch granted address into m_araddr.
  - latch prot into m_arprot; instruction prot is forced to {1'b1, s_i_arprot[1:0]} (instruction access bit set); data prot passes unchanged.
  - latch owner (I/D).
  - update last_grant.
  - set m_arvalid=1.
- R_ADDR: m_araddr, m_arprot and m_arvalid stay stable until m_arready. They clear on the handshake edge.
- R_DATA routing:
  - s_owner_rvalid = m_rvalid.
  - m_rready = s_owner_rready.
  - Non-owner rvalid = 0.
  - m_rdata and m_rresp are broadcast to both s_*_rdata/rresp; only the rvalid qualification differs.
- Reads are not accepted while state != R_IDLE; at most one outstanding read.
- Write path is pure combinational pass-through:
  - m_awvalid=s_d_awvalid, s_d_awready=m_awready, and likewise for addr/prot.
  - W and B channels pass the same way.
  - Writes are independent of the read FSM and may overlap a read.
- Reset (asynchronous assert, any state, including mid-read):
  - state=R_IDLE, m_arvalid=0, m_araddr=0, m_arprot=0.
  - owner=I, last_grant=D, so the first tie goes to I.
  - An in-flight read is abandoned.

## Timing
- Reset values: m_arvalid=0, m_araddr=0, m_arprot=0; all s_*_arready=0, s_*_rvalid=0, m_rready=0. Write-path outputs follow their inputs.
- AR latency: s_x_arvalid high in cycle N with state R_IDLE gives s_x_arready=1 in cycle N and m_arvalid=1 from cycle N+1. This adds 1 cycle.
- R latency: 0 cycles; m_rvalid reaches s_owner_rvalid combinationally.
- Minimum read turnaround: idle→accept→ar handshake→r handshake→idle. The next accept is possible the cycle after the R handshake.
- Write-path latency: 0 cycles in all channels.
- Simultaneous events:
  - m_rvalid&m_rready in the same cycle as a new arvalid: no accept that cycle; the accept occurs the next cycle from R_IDLE.
  - A pending arvalid from the loser remains asserted; it must be granted on the next R_IDLE cycle, since last_grant now favours it.

## Test plan
- Single I read: s_i_araddr=0x0000_0100, slave returns 0xDEAD_BEEF OKAY one cycle after AR → s_i_arready high 1 cycle; m_araddr=0x100, m_arprot=3'b100; s_i_rdata=0xDEAD_BEEF; s_d_rvalid never high.
- Tie alternation: both arvalid held continuously, addresses I=0x10, D=0x20, four reads → m_araddr sequence 0x10,0x20,0x10,0x20; m_arprot 100,000,100,000.
- AR back-pressure: m_arready low for 3 cycles after m_arvalid → m_arvalid/m_araddr stable all 3 cycles; no second s_*_arready until the R handshake completes.
- R back-pressure: m_rvalid=1 while s_d_rready=0 for 2 cycles → m_rready=0 for those cycles; state stays R_DATA; completes when s_d_rready=1.
- Concurrent write: D write addr 0x8000_0000 data 0x1234_5678 strb 0xF during an I read in R_DATA → m_aw*/m_w* mirror inputs the same cycle; s_d_bvalid follows m_bvalid; I read completes correctly.
- Reset mid-read: deassert resetn while in R_DATA → m_arvalid=0 and s_*_rvalid=0 immediately (asynchronous); after release, a simultaneous I/D request grants I first.

Source files
------------

// File: rtl/vigna_axi_arbiter.sv
// Two-master (instruction/data) to one-slave AXI4-Lite arbiter: round-robin reads with
// a single outstanding transaction, write channels passed straight through from the data port.
module vigna_axi_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      resetn,

    input  logic                      s_i_arvalid,
    output logic                      s_i_arready,
    input  logic [ADDR_WIDTH-1:0]     s_i_araddr,
    input  logic [2:0]                s_i_arprot,
    output logic                      s_i_rvalid,
    input  logic                      s_i_rready,
    output logic [DATA_WIDTH-1:0]     s_i_rdata,
    output logic [1:0]                s_i_rresp,

    input  logic                      s_d_arvalid,
    output logic                      s_d_arready,
    input  logic [ADDR_WIDTH-1:0]     s_d_araddr,
    input  logic [2:0]                s_d_arprot,
    output logic                      s_d_rvalid,
    input  logic                      s_d_rready,
    output logic [DATA_WIDTH-1:0]     s_d_rdata,
    output logic [1:0]                s_d_rresp,

    input  logic                      s_d_awvalid,
    output logic                      s_d_awready,
    input  logic [ADDR_WIDTH-1:0]     s_d_awaddr,
    input  logic [2:0]                s_d_awprot,
    input  logic                      s_d_wvalid,
    output logic                      s_d_wready,
    input  logic [DATA_WIDTH-1:0]     s_d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_d_wstrb,
    output logic                      s_d_bvalid,
    input  logic                      s_d_bready,
    output logic [1:0]                s_d_bresp,

    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                m_arprot,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,

    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [1:0]                m_bresp
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic {SRC_I, SRC_D} src_t;

    rstate_t                 r_state;
    src_t                    r_owner;
    src_t                    r_last_grant;
    logic                    r_arvalid;
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic [2:0]              r_arprot;

    logic                    w_idle;
    logic                    w_grant_i;
    logic                    w_grant_d;
    logic                    w_rdata_phase;
    logic                    w_unused_iprot;

    // Instruction prot bit 2 is always forced high, so the incoming bit is not needed.
    assign w_unused_iprot = s_i_arprot[2];

    assign w_idle    = (r_state == R_IDLE);
    assign w_grant_i = s_i_arvalid & (~s_d_arvalid | (r_last_grant == SRC_D));
    assign w_grant_d = s_d_arvalid & (~s_i_arvalid | (r_last_grant == SRC_I));

    assign s_i_arready = w_idle & w_grant_i;
    assign s_d_arready = w_idle & w_grant_d;

    assign m_arvalid = r_arvalid;
    assign m_araddr  = r_araddr;
    assign m_arprot  = r_arprot;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= R_IDLE;
            r_owner      <= SRC_I;
            r_last_grant <= SRC_D;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_arprot     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (w_grant_i || w_grant_d) begin
                        r_state   <= R_ADDR;
                        r_arvalid <= 1'b1;
                        if (w_grant_i) begin
                            r_araddr     <= s_i_araddr;
                            r_arprot     <= {1'b1, s_i_arprot[1:0]};
                            r_owner      <= SRC_I;
                            r_last_grant <= SRC_I;
                        end else begin
                            r_araddr     <= s_d_araddr;
                            r_arprot     <= s_d_arprot;
                            r_owner      <= SRC_D;
                            r_last_grant <= SRC_D;
                        end
                    end
                end
                R_ADDR: begin
                    if (m_arready) begin
                        r_state   <= R_DATA;
                        r_arvalid <= 1'b0;
                        r_araddr  <= '0;
                        r_arprot  <= '0;
                    end
                end
                R_DATA: begin
                    if (m_rvalid && m_rready) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Read data is broadcast; only rvalid/rready are steered to the owner.
    assign w_rdata_phase = (r_state == R_DATA);
    assign s_i_rvalid    = w_rdata_phase & (r_owner == SRC_I) & m_rvalid;
    assign s_d_rvalid    = w_rdata_phase & (r_owner == SRC_D) & m_rvalid;
    assign m_rready      = w_rdata_phase & ((r_owner == SRC_I) ? s_i_rready : s_d_rready);
    assign s_i_rdata     = m_rdata;
    assign s_i_rresp     = m_rresp;
    assign s_d_rdata     = m_rdata;
    assign s_d_rresp     = m_rresp;

    assign m_awvalid   = s_d_awvalid;
    assign s_d_awready = m_awready;
    assign m_awaddr    = s_d_awaddr;
    assign m_awprot    = s_d_awprot;
    assign m_wvalid    = s_d_wvalid;
    assign s_d_wready  = m_wready;
    assign m_wdata     = s_d_wdata;
    assign m_wstrb     = s_d_wstrb;
    assign s_d_bvalid  = m_bvalid;
    assign m_bready    = s_d_bready;
    assign s_d_bresp   = m_bresp;

endmodule

// File: tb/tb_vigna_axi_arbiter.sv
// Bench for vigna_axi_arbiter: table of read transactions with a scoreboard queue,
// plus hand sequences for write pass-through and asynchronous reset.
module tb_vigna_axi_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_i_arvalid, s_i_arready, s_i_rvalid, s_i_rready;
    logic [31:0] s_i_araddr, s_i_rdata;
    logic [2:0]  s_i_arprot;
    logic [1:0]  s_i_rresp;
    logic        s_d_arvalid, s_d_arready, s_d_rvalid, s_d_rready;
    logic [31:0] s_d_araddr, s_d_rdata;
    logic [2:0]  s_d_arprot;
    logic [1:0]  s_d_rresp;
    logic        s_d_awvalid, s_d_awready, s_d_wvalid, s_d_wready, s_d_bvalid, s_d_bready;
    logic [31:0] s_d_awaddr, s_d_wdata;
    logic [2:0]  s_d_awprot;
    logic [3:0]  s_d_wstrb;
    logic [1:0]  s_d_bresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_araddr, m_rdata;
    logic [2:0]  m_arprot;
    logic [1:0]  m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata;
    logic [2:0]  m_awprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;

    vigna_axi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .s_i_arvalid(s_i_arvalid), .s_i_arready(s_i_arready), .s_i_araddr(s_i_araddr),
        .s_i_arprot(s_i_arprot), .s_i_rvalid(s_i_rvalid), .s_i_rready(s_i_rready),
        .s_i_rdata(s_i_rdata), .s_i_rresp(s_i_rresp),
        .s_d_arvalid(s_d_arvalid), .s_d_arready(s_d_arready), .s_d_araddr(s_d_araddr),
        .s_d_arprot(s_d_arprot), .s_d_rvalid(s_d_rvalid), .s_d_rready(s_d_rready),
        .s_d_rdata(s_d_rdata), .s_d_rresp(s_d_rresp),
        .s_d_awvalid(s_d_awvalid), .s_d_awready(s_d_awready), .s_d_awaddr(s_d_awaddr),
        .s_d_awprot(s_d_awprot), .s_d_wvalid(s_d_wvalid), .s_d_wready(s_d_wready),
        .s_d_wdata(s_d_wdata), .s_d_wstrb(s_d_wstrb), .s_d_bvalid(s_d_bvalid),
        .s_d_bready(s_d_bready), .s_d_bresp(s_d_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req_i, req_d;
        logic [31:0] addr_i, addr_d;
        logic [2:0]  prot_i, prot_d;
        int unsigned ar_wait, r_wait;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        wr;
        logic        exp_d;      // 0 = instruction port wins, 1 = data port wins
        logic [31:0] exp_addr;
        logic [2:0]  exp_prot;
    } vec_t;

    typedef struct {
        logic        own_d;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   waited;
        logic got;
        e.own_d = v.exp_d;
        e.addr  = v.exp_addr;
        e.prot  = v.exp_prot;
        e.rdata = v.rdata;
        e.rresp = v.rresp;
        sb.push_back(e);

        s_i_arvalid = v.req_i;  s_i_araddr = v.addr_i;  s_i_arprot = v.prot_i;
        s_d_arvalid = v.req_d;  s_d_araddr = v.addr_d;  s_d_arprot = v.prot_d;
        #1;
        got = 1'b0;
        for (waited = 0; waited < 6; waited++) begin
            if (s_i_arready || s_d_arready) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        chk($sformatf("v%0d_accept_seen", idx), {63'd0, got}, 64'd1);
        if (!got) begin
            void'(sb.pop_front());
            return;
        end
        chk($sformatf("v%0d_arready_i", idx), {63'd0, s_i_arready}, {63'd0, ~v.exp_d});
        chk($sformatf("v%0d_arready_d", idx), {63'd0, s_d_arready}, {63'd0, v.exp_d});
        chk($sformatf("v%0d_arvalid_pre", idx), {63'd0, m_arvalid}, 64'd0);

        @(posedge clk);
        #1;
        if (v.exp_d) s_d_arvalid = 1'b0; else s_i_arvalid = 1'b0;
        for (int unsigned c = 0; c <= v.ar_wait; c++) begin
            m_arready = (c == v.ar_wait);
            #1;
            chk($sformatf("v%0d_c%0d_m_arvalid", idx, c), {63'd0, m_arvalid}, 64'd1);
            chk($sformatf("v%0d_c%0d_m_araddr", idx, c), {32'd0, m_araddr}, {32'd0, sb[0].addr});
            chk($sformatf("v%0d_c%0d_m_arprot", idx, c), {61'd0, m_arprot}, {61'd0, sb[0].prot});
            chk($sformatf("v%0d_c%0d_no_arready", idx, c), {62'd0, s_i_arready, s_d_arready}, 64'd0);
            next_cycle();
        end
        m_arready = 1'b0;
        #1;
        chk($sformatf("v%0d_ar_cleared", idx), {28'd0, m_arvalid, m_arprot, m_araddr}, 64'd0);

        m_rvalid = 1'b1;
        m_rdata  = v.rdata;
        m_rresp  = v.rresp;
        for (int unsigned c = 0; c <= v.r_wait; c++) begin
            if (sb[0].own_d) s_d_rready = (c == v.r_wait); else s_i_rready = (c == v.r_wait);
            #1;
            chk($sformatf("v%0d_c%0d_rvalid", idx, c), {62'd0, s_i_rvalid, s_d_rvalid},
                sb[0].own_d ? 64'd1 : 64'd2);
            chk($sformatf("v%0d_c%0d_m_rready", idx, c), {63'd0, m_rready},
                (c == v.r_wait) ? 64'd1 : 64'd0);
            chk($sformatf("v%0d_c%0d_no_arready", idx, c), {62'd0, s_i_arready, s_d_arready}, 64'd0);
            if (v.wr && c == 0) begin
                s_d_awvalid = 1'b1; s_d_awaddr = 32'h8000_0000; s_d_awprot = 3'b001;
                s_d_wvalid  = 1'b1; s_d_wdata  = 32'h1234_5678; s_d_wstrb  = 4'hF;
                s_d_bready  = 1'b1; m_awready  = 1'b1; m_wready = 1'b0;
                m_bvalid    = 1'b1; m_bresp    = 2'b01;
                #1;
                chk("wr_aw", {28'd0, m_awvalid, m_awprot, m_awaddr}, {28'd0, 1'b1, 3'b001, 32'h8000_0000});
                chk("wr_w", {27'd0, m_wvalid, m_wstrb, m_wdata}, {27'd0, 1'b1, 4'hF, 32'h1234_5678});
                chk("wr_ready_back", {62'd0, s_d_awready, s_d_wready}, 64'd2);
                chk("wr_b", {60'd0, s_d_bvalid, m_bready, s_d_bresp}, {60'd0, 2'b11, 2'b01});
                s_d_awvalid = 1'b0; s_d_wvalid = 1'b0; m_bvalid = 1'b0; s_d_bready = 1'b0;
                m_awready   = 1'b0;
                #1;
                chk("wr_idle", {61'd0, m_awvalid, m_wvalid, s_d_bvalid}, 64'd0);
            end
            next_cycle();
        end
        e = sb.pop_front();
        chk($sformatf("v%0d_rdata", idx), {32'd0, e.own_d ? s_d_rdata : s_i_rdata}, {32'd0, e.rdata});
        chk($sformatf("v%0d_rresp", idx), {62'd0, e.own_d ? s_d_rresp : s_i_rresp}, {62'd0, e.rresp});
        m_rvalid   = 1'b0;
        s_i_rready = 1'b0;
        s_d_rready = 1'b0;
    endtask

    initial begin
        //          req_i req_d addr_i        addr_d        pi      pd      arw rw rdata         resp  wr  expD exp_addr      exp_prot
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        3'b000, 3'b000, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 32'h0000_0100, 3'b100};
        vecs[1] = '{1'b0, 1'b1, 32'h0,        32'h0000_0200, 3'b000, 3'b010, 0, 2, 32'hCAFE_0001, 2'b10, 1'b0, 1'b1, 32'h0000_0200, 3'b010};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0020, 3'b000, 3'b000, 0, 0, 32'h1111_1111, 2'b00, 1'b0, 1'b0, 32'h0000_0010, 3'b100};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0020, 3'b000, 3'b000, 0, 0, 32'h2222_2222, 2'b00, 1'b0, 1'b1, 32'h0000_0020, 3'b000};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0020, 3'b000, 3'b000, 0, 0, 32'h3333_3333, 2'b01, 1'b0, 1'b0, 32'h0000_0010, 3'b100};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0020, 3'b000, 3'b000, 0, 0, 32'h4444_4444, 2'b00, 1'b0, 1'b1, 32'h0000_0020, 3'b000};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,        3'b011, 3'b000, 3, 1, 32'h55AA_55AA, 2'b11, 1'b1, 1'b0, 32'h0000_0400, 3'b111};
        vecs[7] = '{1'b0, 1'b1, 32'h0,        32'h0000_0500, 3'b000, 3'b101, 1, 0, 32'h0F0F_0F0F, 2'b00, 1'b0, 1'b1, 32'h0000_0500, 3'b101};

        resetn = 1'b0;
        s_i_arvalid = 0; s_i_araddr = 0; s_i_arprot = 0; s_i_rready = 0;
        s_d_arvalid = 0; s_d_araddr = 0; s_d_arprot = 0; s_d_rready = 0;
        s_d_awvalid = 0; s_d_awaddr = 0; s_d_awprot = 0; s_d_wvalid = 0; s_d_wdata = 0;
        s_d_wstrb = 0; s_d_bready = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ar", {28'd0, m_arvalid, m_arprot, m_araddr}, 64'd0);
        chk("reset_hs", {60'd0, s_i_arready, s_d_arready, s_i_rvalid, s_d_rvalid}, 64'd0);
        chk("reset_rready", {63'd0, m_rready}, 64'd0);
        resetn = 1'b1;
        next_cycle();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
        s_i_arvalid = 1'b0;
        s_d_arvalid = 1'b0;
        chk("sb_empty", sb.size(), 64'd0);

        // Asynchronous reset while in R_ADDR: m_arvalid must drop without a clock edge.
        next_cycle();
        s_i_arvalid = 1'b1; s_i_araddr = 32'h0000_0300; s_i_arprot = 3'b000;
        next_cycle();
        s_i_arvalid = 1'b0;
        #1;
        chk("rst_addr_pre", {63'd0, m_arvalid}, 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_addr_ar", {28'd0, m_arvalid, m_arprot, m_araddr}, 64'd0);
        resetn = 1'b1;
        next_cycle();

        // Asynchronous reset while in R_DATA with the beat presented.
        s_d_arvalid = 1'b1; s_d_araddr = 32'h0000_0600; s_d_arprot = 3'b001;
        next_cycle();
        s_d_arvalid = 1'b0;
        m_arready = 1'b1;
        next_cycle();
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hABCD_0000; s_d_rready = 1'b1; s_i_rready = 1'b1;
        #1;
        chk("rst_data_pre", {62'd0, s_d_rvalid, m_rready}, 64'd3);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_data_post", {61'd0, s_i_rvalid, s_d_rvalid, m_rready}, 64'd0);
        chk("rst_data_ar", {63'd0, m_arvalid}, 64'd0);
        m_rvalid = 1'b0; s_d_rready = 1'b0; s_i_rready = 1'b0;
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // After reset the first tie goes to the instruction port.
        s_i_arvalid = 1'b1; s_i_araddr = 32'h0000_0700; s_i_arprot = 3'b010;
        s_d_arvalid = 1'b1; s_d_araddr = 32'h0000_0800; s_d_arprot = 3'b000;
        #1;
        chk("post_rst_tie", {62'd0, s_i_arready, s_d_arready}, 64'd2);
        next_cycle();
        s_i_arvalid = 1'b0; s_d_arvalid = 1'b0;
        #1;
        chk("post_rst_addr", {29'd0, m_arprot, m_araddr}, {29'd0, 3'b110, 32'h0000_0700});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
